// File: rtl/alu_arbiter.sv
// Two-channel round-robin front end for a shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC captures the ALU result, RESP holds it until consumed.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [7:0]  req_a_0,
  input  logic [7:0]  req_b_0,
  input  logic [1:0]  req_op_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [7:0]  req_a_1,
  input  logic [7:0]  req_b_1,
  input  logic [1:0]  req_op_1,
  output logic [7:0]  alu_num1,
  output logic [7:0]  alu_num2,
  output logic [1:0]  alu_operation,
  input  logic [15:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  done_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        prio_q, prio_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic        id_q, id_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_id_q, rsp_id_d;
  logic        busy_q, busy_d;
  logic [7:0]  done_q, done_d;
  logic        grant_0, grant_1;
  logic        div_zero;

  // prio_q names the channel that wins a tie; a lone requester wins regardless.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (req_valid_0 && (!req_valid_1 || prio_q == 1'b0)) begin
        grant_0 = 1'b1;
      end else if (req_valid_1) begin
        grant_1 = 1'b1;
      end else begin
        grant_1 = 1'b0;
      end
    end else begin
      grant_0 = 1'b0;
    end
  end

  assign div_zero = (op_q == 2'b11) && (b_q == 8'h00);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_id_d    = rsp_id_q;
    done_d      = done_q;
    case (state_q)
      IDLE: begin
        if (grant_0 || grant_1) begin
          a_d     = grant_1 ? req_a_1 : req_a_0;
          b_d     = grant_1 ? req_b_1 : req_b_0;
          op_d    = grant_1 ? req_op_1 : req_op_0;
          id_d    = grant_1;
          prio_d  = ~grant_1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_data_d = div_zero ? 16'h0000 : alu_out;
        rsp_err_d  = div_zero;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          done_d  = done_q + 8'd1;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      op_q        <= 2'b00;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign req_ready_0   = grant_0;
  assign req_ready_1   = grant_1;
  assign alu_num1      = a_q;
  assign alu_num2      = b_q;
  assign alu_operation = op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_id        = rsp_id_q;
  assign busy          = busy_q;
  assign done_count    = done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural ALU drives alu_out, and a transaction-level model
// (round-robin winner, arithmetic result, completion count) predicts every response.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [7:0]  req_a_0, req_b_0, req_a_1, req_b_1;
  logic [1:0]  req_op_0, req_op_1;
  logic [7:0]  alu_num1, alu_num2;
  logic [1:0]  alu_operation;
  logic [15:0] alu_out;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [15:0] rsp_data;
  logic [7:0]  done_count;

  int tests = 0;
  int fails = 0;
  int exp_done = 0;
  logic last_grant = 1'b1;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_a_0(req_a_0), .req_b_0(req_b_0), .req_op_0(req_op_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_a_1(req_a_1), .req_b_1(req_b_1), .req_op_1(req_op_1),
    .alu_num1(alu_num1), .alu_num2(alu_num2), .alu_operation(alu_operation), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  // External ALU; divide by zero yields junk that the DUT must discard.
  always_comb begin
    case (alu_operation)
      2'd0:    alu_out = 16'(alu_num1) + 16'(alu_num2);
      2'd1:    alu_out = 16'(alu_num1) - 16'(alu_num2);
      2'd2:    alu_out = 16'(alu_num1) * 16'(alu_num2);
      default: alu_out = (alu_num2 == 8'd0) ? 16'hDEAD : {8'h00, alu_num1 / alu_num2};
    endcase
  end

  function automatic logic [16:0] ref_result(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    int unsigned r;
    logic err;
    err = 1'b0;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b);
      2'd2:    r = int'(a) * int'(b);
      default: begin
        if (b == 8'd0) begin r = 0; err = 1'b1; end
        else r = int'(a) / int'(b);
      end
    endcase
    return {err, r[15:0]};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_done = 0;
    last_grant = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the response is consumed.
  task automatic do_txn(input logic v0, input logic v1,
                        input logic [7:0] a0, input logic [7:0] b0, input logic [1:0] op0,
                        input logic [7:0] a1, input logic [7:0] b1, input logic [1:0] op1,
                        input int stall, input logic hold);
    logic win;
    logic [7:0] wa, wb;
    logic [1:0] wop;
    logic [16:0] exp;
    req_valid_0 = v0; req_a_0 = a0; req_b_0 = b0; req_op_0 = op0;
    req_valid_1 = v1; req_a_1 = a1; req_b_1 = b1; req_op_1 = op1;
    #1;
    win = (v0 && v1) ? ~last_grant : !v0;
    tests++;
    if (req_ready_0 !== !win || req_ready_1 !== win) begin
      fails++;
      $display("FAIL grant: ready0=%b ready1=%b, required winner ch%0d", req_ready_0, req_ready_1, win);
    end
    last_grant = win;
    wa = win ? a1 : a0;
    wb = win ? b1 : b0;
    wop = win ? op1 : op0;
    exp = ref_result(wa, wb, wop);
    @(negedge clk);
    if (!win || !hold) req_valid_0 = 1'b0;
    if (win || !hold) req_valid_1 = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0 ||
        alu_num1 !== wa || alu_num2 !== wb || alu_operation !== wop) begin
      fails++;
      $display("FAIL exec: busy=%b rsp_valid=%b rdy=%b%b alu=%h,%h,%h required 1,0,00,%h,%h,%h",
               busy, rsp_valid, req_ready_0, req_ready_1, alu_num1, alu_num2, alu_operation, wa, wb, wop);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== exp[15:0] || rsp_err !== exp[16] || rsp_id !== win) begin
      fails++;
      $display("FAIL rsp: valid=%b data=%h err=%b id=%b required 1 %h %b %b",
               rsp_valid, rsp_data, rsp_err, rsp_id, exp[15:0], exp[16], win);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp[15:0] || rsp_err !== exp[16] || rsp_id !== win ||
          req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0 || alu_num1 !== wa || busy !== 1'b1) begin
        fails++;
        $display("FAIL stall%0d: valid=%b data=%h err=%b id=%b rdy=%b%b required 1 %h %b %b 00",
                 i, rsp_valid, rsp_data, rsp_err, rsp_id, req_ready_0, req_ready_1, exp[15:0], exp[16], win);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_done = (exp_done + 1) % 256;
    tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 8'(exp_done)) begin
      fails++;
      $display("FAIL done: valid=%b busy=%b count=%0d required 0 0 %0d", rsp_valid, busy, done_count, exp_done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_err !== 1'b0 || rsp_id !== 1'b0) begin
      fails++;
      $display("FAIL reset_rsp: valid=%b data=%h err=%b id=%b required all 0", rsp_valid, rsp_data, rsp_err, rsp_id);
    end
    tests++;
    if (busy !== 1'b0 || done_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_status: busy=%b count=%0d required 0 0", busy, done_count);
    end
    tests++;
    if (alu_num1 !== 8'd0 || alu_num2 !== 8'd0 || alu_operation !== 2'd0 || req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_alu: %h %h %h rdy=%b%b required 00 00 0 00", alu_num1, alu_num2, alu_operation, req_ready_0, req_ready_1);
    end
  endtask

  task automatic test_basic();
    do_txn(1'b1, 1'b0, 8'd2, 8'd2, 2'b00, 8'd0, 8'd0, 2'b00, 0, 1'b0);
    tests++;
    if (done_count !== 8'd1) begin
      fails++;
      $display("FAIL basic_count: count=%0d required 1", done_count);
    end
  endtask

  task automatic test_rr_pair();
    do_reset();
    do_txn(1'b1, 1'b1, 8'd3, 8'd1, 2'b01, 8'd3, 8'd2, 2'b10, 0, 1'b1);
    do_txn(1'b1, 1'b1, 8'd3, 8'd1, 2'b01, 8'd3, 8'd2, 2'b10, 1, 1'b0);
    do_txn(1'b0, 1'b1, 8'd0, 8'd0, 2'b00, 8'd7, 8'd9, 2'b01, 0, 1'b0);
  endtask

  task automatic test_div_zero();
    do_txn(1'b0, 1'b1, 8'd0, 8'd0, 2'b00, 8'd4, 8'd0, 2'b11, 0, 1'b0);
    do_txn(1'b1, 1'b0, 8'd200, 8'd7, 2'b11, 8'd0, 8'd0, 2'b00, 0, 1'b0);
  endtask

  task automatic test_stall();
    do_txn(1'b1, 1'b0, 8'd10, 8'd20, 2'b10, 8'd0, 8'd0, 2'b00, 0, 1'b0);
    do_txn(1'b1, 1'b1, 8'd5, 8'd6, 2'b00, 8'd250, 8'd251, 2'b10, 5, 1'b1);
    do_txn(1'b1, 1'b0, 8'd5, 8'd6, 2'b00, 8'd0, 8'd0, 2'b00, 0, 1'b0);
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    req_valid_0 = 1'b1; req_a_0 = 8'd5; req_b_0 = 8'd6; req_op_0 = 2'b00;
    @(negedge clk);
    req_valid_0 = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL rst_exec_busy: busy=%b required 1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_count !== 8'd0 || alu_num1 !== 8'd0 || alu_operation !== 2'd0) begin
        fails++;
        $display("FAIL rst_exec%0d: valid=%b busy=%b count=%0d num1=%h required 0 0 0 00",
                 i, rsp_valid, busy, done_count, alu_num1);
      end
      @(negedge clk);
    end
    exp_done = 0;
    last_grant = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic v0, v1;
      logic [7:0] b0, b1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      b0 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      do_txn(v0, v1, 8'($urandom), b0, 2'($urandom), 8'($urandom), b1, 2'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 256; n++) begin
      do_txn(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 2'($urandom),
             8'($urandom), 8'($urandom), 2'($urandom), 0, 1'b0);
    end
    tests++;
    if (done_count !== 8'd0) begin
      fails++;
      $display("FAIL wrap: count=%0d required 0", done_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid_0 = 1'b0; req_a_0 = 8'd0; req_b_0 = 8'd0; req_op_0 = 2'd0;
    req_valid_1 = 1'b0; req_a_1 = 8'd0; req_b_1 = 8'd0; req_op_1 = 2'd0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_rr_pair();
    test_div_zero();
    test_stall();
    test_reset_mid_exec();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 The block SHALL have the following per-channel ports for channel n in {0,1}:
  req_valid_n  input  1  operation request pending
  req_ready_n  output 1  request accepted this cycle
  req_a_n      input  8  first operand (num1)
  req_b_n      input  8  second operand (num2)
  req_op_n     input  2  00 add, 01 sub, 10 mul, 11 div
REQ-003 The block SHALL have the following shared ALU ports (ALU is purely combinational):
  alu_num1       output 8   operand to ALU
  alu_num2       output 8   operand to ALU
  alu_operation  output 2   opcode to ALU
  alu_out        input  16  ALU result
REQ-004 The block SHALL have the following response and status ports:
  rsp_valid   output 1   response available
  rsp_ready   input  1   consumer accepts response
  rsp_id      output 1   channel that issued the operation
  rsp_data    output 16  result
  rsp_err     output 1   divide-by-zero flag
  busy        output 1   high in any state other than IDLE
  done_count  output 8   completed responses, wraps
REQ-005 The block SHALL have no parameters; all widths are fixed as listed above.

Function
REQ-006 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-007 In IDLE with at least one req_valid_n high, the block SHALL assert req_ready only for the winner, combinationally in the same cycle; all other req_ready outputs SHALL be 0 in every state.
REQ-008 Arbitration SHALL be round-robin: if both channels are valid, the winner is the channel not granted last; if only one is valid, it wins regardless of the pointer.
REQ-009 The round-robin pointer SHALL update only on a request handshake.
REQ-010 On a handshake (req_valid_n and req_ready_n both high) the block SHALL register a, b, op and id into operand registers and move to EXEC.
REQ-011 alu_num1, alu_num2 and alu_operation SHALL always be driven from the operand registers and SHALL be stable from EXEC through RESP.
REQ-012 In EXEC the block SHALL capture alu_out into the result register and move to RESP after exactly one cycle.
REQ-013 If the registered op is 11 and the registered b is 0, the block SHALL set rsp_data to 16'h0000 and rsp_err to 1, ignoring alu_out; otherwise rsp_err SHALL be 0.
REQ-014 The block SHALL pass alu_out through unmodified; it performs no sign or width conversion.
REQ-015 In RESP, rsp_valid SHALL be 1, and rsp_data, rsp_err and rsp_id SHALL be held stable until rsp_ready is high.
REQ-016 On the RESP handshake the block SHALL return to IDLE, drop rsp_valid the next cycle, and increment done_count modulo 256 (255 SHALL wrap to 0).
REQ-017 Request-to-response latency SHALL be 2 cycles: handshake in cycle T, rsp_valid high in cycle T+2.
REQ-018 Minimum issue interval SHALL be 3 cycles per operation.
REQ-019 A new request SHALL NOT be accepted while in EXEC or RESP, and requesters SHALL hold request fields stable while waiting.
REQ-020 A req_valid that drops before its handshake SHALL be ignored without error.
REQ-021 A response that stalls indefinitely (rsp_ready held low) SHALL keep the FSM in RESP with all outputs held.

Reset
REQ-022 rst SHALL take effect on the rising clk edge and override all other activity, including an operation mid-EXEC or mid-RESP, which SHALL be discarded without a response.
REQ-023 After reset: state IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_id=0, busy=0, done_count=0, operand registers=0 (alu_num1=alu_num2=0, alu_operation=00), pointer giving channel 0 priority.

Verification
REQ-024 Ch0 a=2,b=2,op=00 -> req_ready_0 in cycle T; rsp_valid at T+2 with rsp_data=4, rsp_id=0, rsp_err=0; done_count=1.
REQ-025 Both channels valid in the same cycle after reset (ch0 3-1 op=01, ch1 3*2 op=10) -> ch0 served first (data=2), then ch1 (data=6), then a repeated pair is granted ch1 first.
REQ-026 Ch1 a=4,b=0,op=11 -> rsp_err=1, rsp_data=0, rsp_id=1.
REQ-027 rsp_ready held low 5 cycles in RESP -> rsp_valid and data stable; a pending req_valid_0 sees req_ready_0=0 throughout.
REQ-028 rst asserted during EXEC -> next cycle IDLE, rsp_valid=0, done_count unchanged at 0, no response emitted.
REQ-029 256 back-to-back completed operations -> done_count wraps to 0.
